mm_2x2_seq_ctrl: RTL and testbench

//  Sequencer for the 2x2 systolic multiply array (input skew FIFOs + four PEs).
//  On start: clears PE accumulators, streams k_len operand beats (one A-row/B-col

---
 rtl/mm_2x2_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_mm_2x2_seq_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_2x2_seq_ctrl.sv
// ============================================================================
// mm_2x2_seq_ctrl: job sequencer for the 2x2 systolic multiply array.
// Clears the PEs, streams k operand beats, drains the wavefront, pulses done.
// Optional feature macro: STALL_CNT_EN (FEED-cycle stall counter on stall_cnt).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mm_2x2_seq_ctrl #(
  parameter int MAX_K     = 16,
  parameter int KW        = 5,
  parameter int DRAIN_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  input  logic          op_ready,
  output logic [KW-1:0] op_addr,
  output logic          feed_valid,
  output logic          pe_clr,
  output logic          busy,
  output logic          done,
  output logic [15:0]   stall_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [KW-1:0] MAX_K_W    = KW'(MAX_K);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [KW-1:0] op_addr_q, op_addr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          pe_clr_q, pe_clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    state_d   = state_q;
    klen_d    = klen_q;
    op_addr_d = op_addr_q;
    drain_d   = drain_q;
    pe_clr_d  = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          klen_d    = (k_len > MAX_K_W) ? MAX_K_W : k_len;
          op_addr_d = '0;
          pe_clr_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        drain_d = '0;
        state_d = (klen_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        // A stalled beat simply holds op_addr; no timeout on op_ready.
        if (op_ready) begin
          if (op_addr_q == klen_q - KW'(1)) begin
            op_addr_d = '0;
            drain_d   = '0;
            state_d   = S_DRAIN;
          end else begin
            op_addr_d = op_addr_q + KW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      klen_q    <= '0;
      op_addr_q <= '0;
      drain_q   <= '0;
      pe_clr_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      klen_q    <= klen_d;
      op_addr_q <= op_addr_d;
      drain_q   <= drain_d;
      pe_clr_q  <= pe_clr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // The array valids must follow op_ready within the same cycle.
  assign feed_valid = (state_q == S_FEED) && op_ready;
  assign op_addr    = op_addr_q;
  assign pe_clr     = pe_clr_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_CLEAR) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_FEED) && !op_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_2x2_seq_ctrl.sv
// ============================================================================
// tb_mm_2x2_seq_ctrl: self-checking bench for the 2x2 array sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mm_2x2_seq_ctrl;

  localparam int MAX_K     = 16;
  localparam int KW        = 5;
  localparam int DRAIN_CYC = 3;
  localparam int NEVER     = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          op_ready;
  logic [KW-1:0] op_addr;
  logic          feed_valid;
  logic          pe_clr;
  logic          busy;
  logic          done;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  mm_2x2_seq_ctrl #(
    .MAX_K    (MAX_K),
    .KW       (KW),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .op_ready  (op_ready),
    .op_addr   (op_addr),
    .feed_valid(feed_valid),
    .pe_clr    (pe_clr),
    .busy      (busy),
    .done      (done),
    .stall_cnt (stall_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Job-timeline reference: a job is described by when it was accepted,
  // how many beats it has delivered and when its done cycle falls.
  bit m_job   = 1'b0;
  int m_cyc   = 0;
  int m_tacc  = 0;
  int m_tend  = NEVER;
  int m_klen  = 0;
  int m_beats = 0;
  int m_stall = 0;

  logic          seen_fv, seen_done, seen_busy;
  logic [KW-1:0] seen_addr;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, m_cyc, got, exp);
    end
  endtask

  task automatic model_check(input bit rdy);
    bit e_clr, feeding;
    e_clr   = m_job && (m_cyc == m_tacc + 1);
    feeding = m_job && (m_cyc >= m_tacc + 2) && (m_beats < m_klen);
    chk("pe_clr", int'(pe_clr), int'(e_clr));
    chk("feed_valid", int'(feed_valid), int'(feeding && rdy));
    chk("op_addr", int'(op_addr), feeding ? m_beats : 0);
    chk("busy", int'(busy), int'(m_job));
    chk("done", int'(done), int'(m_job && (m_cyc == m_tend)));
`ifdef STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
`else
    chk("stall_cnt", int'(stall_cnt), 0);
`endif
  endtask

  task automatic model_update(input bit r, input bit s, input int k, input bit rdy);
    bit e_clr, feeding;
    e_clr   = m_job && (m_cyc == m_tacc + 1);
    feeding = m_job && (m_cyc >= m_tacc + 2) && (m_beats < m_klen);
    if (r) begin
      m_job   = 1'b0;
      m_stall = 0;
    end else if (m_job) begin
      if (e_clr) begin
        m_stall = 0;
        if (m_klen == 0) m_tend = m_cyc + DRAIN_CYC + 1;
      end
      if (feeding) begin
        if (rdy) begin
          m_beats++;
          if (m_beats == m_klen) m_tend = m_cyc + DRAIN_CYC + 1;
        end else if (m_stall < 16'hFFFF) begin
          m_stall++;
        end
      end
      if (m_cyc == m_tend) m_job = 1'b0;
    end else if (s) begin
      m_job   = 1'b1;
      m_tacc  = m_cyc;
      m_klen  = (k > MAX_K) ? MAX_K : k;
      m_beats = 0;
      m_tend  = NEVER;
    end
    m_cyc++;
  endtask

  task automatic step(input bit r, input bit s, input int k, input bit rdy);
    rst      = r;
    start    = s;
    k_len    = KW'(k);
    op_ready = rdy;
    #1;
    model_check(rdy);
    seen_fv   = feed_valid;
    seen_done = done;
    seen_busy = busy;
    seen_addr = op_addr;
    model_update(r, s, k, rdy);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic          start;
    logic [KW-1:0] k;
    logic          rdy;
    logic          clr;
    logic          fv;
    logic [KW-1:0] addr;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // k_len=2 job (k_len changed mid-job), then a k_len=0 job
    tbl[0]  = '{1'b0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    k_len    = '0;
    op_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op_addr", int'(op_addr), 0);
    chk("rst_feed_valid", int'(feed_valid), 0);
    chk("rst_pe_clr", int'(pe_clr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);

    for (int i = 0; i < 16; i++) begin
      rst      = tbl[i].rst;
      start    = tbl[i].start;
      k_len    = tbl[i].k;
      op_ready = tbl[i].rdy;
      #1;
      chk("tbl_pe_clr", int'(pe_clr), int'(tbl[i].clr));
      chk("tbl_feed_valid", int'(feed_valid), int'(tbl[i].fv));
      chk("tbl_op_addr", int'(op_addr), int'(tbl[i].addr));
      chk("tbl_busy", int'(busy), int'(tbl[i].busy));
      chk("tbl_done", int'(done), int'(tbl[i].done));
      model_update(tbl[i].rst, tbl[i].start, int'(tbl[i].k), tbl[i].rdy);
      @(posedge clk);
      #1;
    end

    // k_len=4 with op_ready low for two cycles while op_addr==1
    begin
      int done_at;
      done_at = -1;
      for (int i = 0; i < 40; i++) begin
        step(1'b0, i == 0, 4, !(i == 3 || i == 4));
        if (seen_done && done_at < 0) done_at = i;
      end
      chk("stall_done_latency", done_at, 11);
`ifdef STALL_CNT_EN
      chk("stall_cnt_held", int'(stall_cnt), 2);
`else
      chk("stall_cnt_tied", int'(stall_cnt), 0);
`endif
    end

    // start held high throughout a k_len=3 job, re-accepted after done
    begin
      int  dones;
      bit  busy_ok;
      dones   = 0;
      busy_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 1'b1, 3, 1'b1);
        if (seen_done) dones++;
        if (i >= 1 && i <= 8 && !seen_busy) busy_ok = 1'b0;
      end
      chk("held_start_dones", dones, 1);
      chk("held_start_busy", int'(busy_ok), 1);
      step(1'b0, 1'b0, 3, 1'b1);
      chk("restart_busy", int'(seen_busy), 1);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 0, 1'b1);
    end

    // reset while feeding op_addr 2 of a k_len=5 job
    begin
      int dones;
      dones = 0;
      for (int i = 0; i < 4; i++) step(1'b0, i == 0, 5, 1'b1);
      step(1'b1, 1'b0, 5, 1'b1);
      chk("addr_at_rst", int'(seen_addr), 2);
      step(1'b0, 1'b0, 5, 1'b1);
      chk("post_rst_busy", int'(seen_busy), 0);
      chk("post_rst_addr", int'(seen_addr), 0);
      for (int i = 0; i < 12; i++) begin
        step(1'b0, 1'b0, 5, 1'b1);
        if (seen_done) dones++;
      end
      chk("post_rst_no_done", dones, 0);
    end

    // k_len=31 clamps to MAX_K beats
    begin
      int beats, max_addr;
      beats    = 0;
      max_addr = 0;
      for (int i = 0; i < 30; i++) begin
        step(1'b0, i == 0, 31, 1'b1);
        if (seen_fv) begin
          beats++;
          if (int'(seen_addr) > max_addr) max_addr = int'(seen_addr);
        end
      end
      chk("clamp_beats", beats, MAX_K);
      chk("clamp_max_addr", max_addr, MAX_K - 1);
    end

    // randomized traffic against the timeline model
    for (int i = 0; i < 800; i++) begin
      int k;
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(17, 31))
                                      : int'($urandom_range(0, 8));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, k,
           $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
